brushless_comm: RTL and testbench

//  Commutation controller driving the motor-drive block's selGrn/selYlw/selBlu and duty inputs.
//  - Synchronises the three hall sensors.
//  - Samples them once per PWM period, on PWM_synch from the motor drive.
//  - Maps rotation state to per-phase drive codes.
//  - Applies regen braking and stall shutdown.

---
 rtl/brushless_comm_if.sv | 25 ++
 rtl/brushless_comm.sv | 137 +++++++++++++
 tb/tb_brushless_comm.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/brushless_comm_if.sv
// Bundle between the commutation controller and its environment: hall/brake/magnitude/PWM
// inputs and the phase codes, duty and stall flag that feed the motor-drive block.
interface brushless_comm_if;
    logic        hallGrn;
    logic        hallYlw;
    logic        hallBlu;
    logic        brake_n;
    logic [11:0] drv_mag;
    logic        PWM_synch;
    logic [10:0] duty;
    logic [1:0]  selGrn;
    logic [1:0]  selYlw;
    logic [1:0]  selBlu;
    logic        stall;

    modport master (
        output hallGrn, hallYlw, hallBlu, brake_n, drv_mag, PWM_synch,
        input  duty, selGrn, selYlw, selBlu, stall
    );

    modport slave (
        input  hallGrn, hallYlw, hallBlu, brake_n, drv_mag, PWM_synch,
        output duty, selGrn, selYlw, selBlu, stall
    );
endinterface

// File: rtl/brushless_comm.sv
// Brushless commutation controller: hall sync, per-PWM-period sampling, phase table, regen brake, stall.
// Optional macro HALL_GLITCH_FILT_EN: require two equal consecutive PWM samples before accepting a hall state.
module brushless_comm #(
    parameter int STALL_PERIODS = 1024
) (
    input logic             clk,
    input logic             rst_n,
    brushless_comm_if.slave bus
);
    localparam int CW = $clog2(STALL_PERIODS + 1);

    typedef enum logic [1:0] {
        HIGH_Z      = 2'b00,
        REV_CURR    = 2'b01,
        FRWD_CURR   = 2'b10,
        REGEN_BRAKE = 2'b11
    } phase_e;

    function automatic logic [5:0] comm_lut(input logic [2:0] st);
        phase_e g, y, b;
        g = HIGH_Z;
        y = HIGH_Z;
        b = HIGH_Z;
        case (st)
            3'b101: begin g = FRWD_CURR; y = REV_CURR;  b = HIGH_Z;    end
            3'b100: begin g = FRWD_CURR; y = HIGH_Z;    b = REV_CURR;  end
            3'b110: begin g = HIGH_Z;    y = FRWD_CURR; b = REV_CURR;  end
            3'b010: begin g = REV_CURR;  y = FRWD_CURR; b = HIGH_Z;    end
            3'b011: begin g = REV_CURR;  y = HIGH_Z;    b = FRWD_CURR; end
            3'b001: begin g = HIGH_Z;    y = REV_CURR;  b = FRWD_CURR; end
            default: ;
        endcase
        return {g, y, b};
    endfunction

    // {grn, ylw, blu, brake_n} through a two-flop synchroniser
    logic [3:0] sync1_q, sync2_q;
    logic [2:0] hall_s;
    logic       brake_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= {bus.hallGrn, bus.hallYlw, bus.hallBlu, bus.brake_n};
            sync2_q <= sync1_q;
        end
    end

    assign hall_s  = sync2_q[3:1];
    assign brake_s = ~sync2_q[0];

    logic [2:0]    rot_q, rot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall_q, stall_d;
    logic [5:0]    sel_q, sel_d;
    logic [10:0]   duty_q, duty_d;
    logic          state_chg;

`ifdef HALL_GLITCH_FILT_EN
    logic [2:0] cand_q, cand_d;

    always_comb begin
        cand_d = cand_q;
        rot_d  = rot_q;
        if (bus.PWM_synch) begin
            cand_d = hall_s;
            if (hall_s == cand_q) rot_d = hall_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cand_q <= 3'b000;
        else        cand_q <= cand_d;
    end
`else
    always_comb begin
        rot_d = rot_q;
        if (bus.PWM_synch) rot_d = hall_s;
    end
`endif

    assign state_chg = (rot_d != rot_q);

    // Brake clears on any clock; otherwise the counter only moves on PWM periods
    always_comb begin
        cnt_d   = cnt_q;
        stall_d = stall_q;
        if (brake_s) begin
            cnt_d   = '0;
            stall_d = 1'b0;
        end else if (bus.PWM_synch) begin
            if (bus.drv_mag == 12'h000 || state_chg) begin
                cnt_d   = '0;
                stall_d = 1'b0;
            end else begin
                if (cnt_q != CW'(STALL_PERIODS)) cnt_d = cnt_q + CW'(1);
                if (cnt_d == CW'(STALL_PERIODS)) stall_d = 1'b1;
            end
        end
    end

    always_comb begin
        sel_d  = comm_lut(rot_q);
        duty_d = 11'h400 + 11'(bus.drv_mag[11:2]);
        if (brake_s) begin
            sel_d  = {REGEN_BRAKE, REGEN_BRAKE, REGEN_BRAKE};
            duty_d = 11'h600;
        end else if (stall_q) begin
            sel_d  = {HIGH_Z, HIGH_Z, HIGH_Z};
            duty_d = 11'h400;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_q   <= 3'b000;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            sel_q   <= 6'b000000;
            duty_q  <= 11'h000;
        end else begin
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            sel_q   <= sel_d;
            duty_q  <= duty_d;
        end
    end

    assign bus.selGrn = sel_q[5:4];
    assign bus.selYlw = sel_q[3:2];
    assign bus.selBlu = sel_q[1:0];
    assign bus.duty   = duty_q;
    assign bus.stall  = stall_q;
endmodule

// File: tb/tb_brushless_comm.sv
// Directed + randomized bench for brushless_comm, checked every clock against a reference model.
module tb_brushless_comm;
    localparam int SP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    brushless_comm_if bus ();
    brushless_comm #(.STALL_PERIODS(SP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // Commutation table, indexed by {Grn,Ylw,Blu}; value {selGrn,selYlw,selBlu}
    logic [5:0] lut [8];
    initial begin
        lut[0] = 6'b000000; lut[7] = 6'b000000;
        lut[5] = 6'b100100; lut[4] = 6'b100001;
        lut[6] = 6'b001001; lut[2] = 6'b011000;
        lut[3] = 6'b010010; lut[1] = 6'b000110;
    end

    // Reference model: pipeline histories of hall/brake, accepted state, stall bookkeeping
    logic [2:0] h_hist [2];
    logic       b_hist [2];
    logic [2:0] m_rot, m_cand;
    int         m_cnt;
    logic       m_stall;
    logic [17:0] exp_o;

    task automatic model_reset();
        h_hist[0] = 3'b000; h_hist[1] = 3'b000;
        b_hist[0] = 1'b0;   b_hist[1] = 1'b0;
        m_rot = 3'b000; m_cand = 3'b000; m_cnt = 0; m_stall = 1'b0;
        exp_o = 18'h0;
    endtask

    task automatic model_edge();
        logic [2:0]  hs, nrot;
        logic        braking;
        logic [5:0]  es;
        logic [10:0] ed;
        hs      = h_hist[1];
        braking = !b_hist[1];
        if (braking)      begin es = 6'b111111; ed = 11'h600; end
        else if (m_stall) begin es = 6'b000000; ed = 11'h400; end
        else begin es = lut[m_rot]; ed = 11'h400 + 11'(bus.drv_mag / 4); end
        nrot = m_rot;
        if (bus.PWM_synch) begin
`ifdef HALL_GLITCH_FILT_EN
            if (hs == m_cand) nrot = hs;
            m_cand = hs;
`else
            nrot = hs;
`endif
        end
        if (braking) begin
            m_cnt = 0; m_stall = 1'b0;
        end else if (bus.PWM_synch) begin
            if (bus.drv_mag == 0 || nrot != m_rot) begin
                m_cnt = 0; m_stall = 1'b0;
            end else begin
                m_cnt = (m_cnt + 1 > SP) ? SP : m_cnt + 1;
                if (m_cnt == SP) m_stall = 1'b1;
            end
        end
        m_rot = nrot;
        h_hist[1] = h_hist[0]; h_hist[0] = {bus.hallGrn, bus.hallYlw, bus.hallBlu};
        b_hist[1] = b_hist[0]; b_hist[0] = bus.brake_n;
        exp_o = {es, ed, m_stall};
    endtask

    function automatic logic [17:0] obs();
        return {bus.selGrn, bus.selYlw, bus.selBlu, bus.duty, bus.stall};
    endfunction

    task automatic check(input string tag, input logic [17:0] expv);
        logic [17:0] o;
        o = obs();
        n_cmp++;
        assert (o === expv) else begin
            n_err++;
            $error("FAIL %s: observed sel=%b duty=%h stall=%b, expected sel=%b duty=%h stall=%b",
                   tag, o[17:12], o[11:1], o[0], expv[17:12], expv[11:1], expv[0]);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, exp_o);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic set_hall(input logic [2:0] h);
        {bus.hallGrn, bus.hallYlw, bus.hallBlu} = h;
    endtask

    task automatic pulse(input string tag);
        bus.PWM_synch = 1'b1;
        tick(tag);
        bus.PWM_synch = 1'b0;
    endtask

    // Lets a new hall value settle through sync, then samples it (twice when filtered)
    task automatic sample(input string tag);
        ticks(tag, 3);
        pulse(tag);
`ifdef HALL_GLITCH_FILT_EN
        ticks(tag, 2);
        pulse(tag);
`endif
        ticks(tag, 2);
    endtask

    logic [2:0] seq [6];

    initial begin
        seq[0] = 3'b100; seq[1] = 3'b110; seq[2] = 3'b010;
        seq[3] = 3'b011; seq[4] = 3'b001; seq[5] = 3'b111;
        set_hall(3'b000);
        bus.brake_n = 1'b1; bus.drv_mag = 12'h000; bus.PWM_synch = 1'b0;
        model_reset();
        #12;
        check("reset", 18'h0);
        rst_n = 1'b1;

        // First state, clean drive
        set_hall(3'b101); bus.drv_mag = 12'h800;
        sample("first");
        check("first_const", {6'b100100, 11'h600, 1'b0});

        // Table walk
        foreach (seq[i]) begin
            set_hall(seq[i]);
            sample("walk");
            check($sformatf("walk_%b", seq[i]), {lut[seq[i]], 11'h600, 1'b0});
        end

        // Hall moves but no PWM_synch: outputs must hold the illegal-state HIGH_Z
        set_hall(3'b101);
        ticks("nopwm", 100);
        check("nopwm_const", {6'b000000, 11'h600, 1'b0});
        sample("nopwm_upd");
        check("nopwm_upd_const", {6'b100100, 11'h600, 1'b0});

        // Brake: three clocks to reach the outputs
        bus.brake_n = 1'b0;
        ticks("brake", 3);
        check("brake_const", {6'b111111, 11'h600, 1'b0});
        bus.brake_n = 1'b1;
        ticks("unbrake", 3);

        // Stall with fixed hall
        bus.drv_mag = 12'h100;
        for (int i = 0; i < SP; i++) begin
            ticks("stall_run", 2);
            pulse("stall_run");
        end
        tick("stall");
        check("stall_const", {6'b000000, 11'h400, 1'b1});
        set_hall(3'b100);
        sample("unstall");
        check("unstall_const", {6'b100001, 11'h440, 1'b0});

`ifdef HALL_GLITCH_FILT_EN
        set_hall(3'b110);
        ticks("glitch", 3);
        pulse("glitch");
        set_hall(3'b100);
        ticks("glitch", 3);
        pulse("glitch");
        ticks("glitch", 2);
        check("glitch_const", {6'b100001, 11'h440, 1'b0});
`endif

        // Async reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst", 18'h0);
        model_reset();
        #1 rst_n = 1'b1;

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) set_hall(3'($urandom));
            bus.brake_n   = ($urandom_range(0, 63) != 0);
            bus.PWM_synch = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0)
                bus.drv_mag = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
